// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the receive FIFO and its consumer.
// The master side feeds received bytes and pulls them back out; the slave is the FIFO.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rx_data,
    output rx_done,
    output rx_error,
    output rd_ready,
    input  rd_data,
    input  rd_err,
    input  rd_valid
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  rx_error,
    input  rd_ready,
    output rd_data,
    output rd_err,
    output rd_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART receiver. Each entry holds {framing_err, byte}.
// Fill level, almost-full and a sticky overrun flag come from registered pointer/count state.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus,
  input  logic            clr_overrun,
  output logic [ADDR_W:0] fifo_count,
  output logic            empty,
  output logic            full,
  output logic            almost_full,
  output logic            overrun
);
  localparam int DATA_W = 8;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);

  logic [DATA_W:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic [DATA_W:0] head;
  logic            do_push;
  logic            do_pop;
  logic            drop;

  // A pop frees the slot this same cycle, so a full FIFO can still accept.
  assign do_pop  = !empty && bus.rd_ready;
  assign do_push = bus.rx_done && (!full || do_pop);
  assign drop    = bus.rx_done && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= {bus.rx_error, bus.rx_data};
  end

  assign head        = mem[rd_ptr[ADDR_W-1:0]];
  assign fifo_count  = count;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);

  // Head is masked while empty so stale storage never leaks out.
  assign bus.rd_valid = !empty;
  assign bus.rd_data  = empty ? '0   : head[DATA_W-1:0];
  assign bus.rd_err   = empty ? 1'b0 : head[DATA_W];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed stimulus with a queue scoreboard popped by a read monitor.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_overrun;
  logic [4:0] fifo_count;
  logic       empty, full, almost_full, overrun;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];
  int mcount = 0;
  bit moverrun = 1'b0;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_LEVEL(12)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .clr_overrun(clr_overrun),
    .fifo_count(fifo_count),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs settle 1 after each edge, so negedge sees what the next edge will accept.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid && bus.rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %0h expected no entry", {bus.rd_err, bus.rd_data});
      end else begin
        check("rd_head", {23'd0, bus.rd_err, bus.rd_data}, {23'd0, sb.pop_front()});
      end
    end
  end

  task automatic check_status();
    check("fifo_count", fifo_count, mcount);
    check("empty", empty, mcount == 0);
    check("full", full, mcount == 16);
    check("almost_full", almost_full, mcount >= 12);
    check("overrun", overrun, moverrun);
    check("rd_valid", bus.rd_valid, mcount != 0);
    if (mcount == 0) check("rd_empty_zero", {bus.rd_err, bus.rd_data}, 9'd0);
  endtask

  task automatic cycle(input bit done, input logic [7:0] data, input bit err,
                       input bit ready, input bit clr);
    bit pop, push;
    bus.rx_done  = done;
    bus.rx_data  = data;
    bus.rx_error = err;
    bus.rd_ready = ready;
    clr_overrun  = clr;
    pop  = (mcount != 0) && ready;
    push = done && ((mcount != 16) || pop);
    if (push) sb.push_back({err, data});
    mcount = mcount + int'(push) - int'(pop);
    if (done && !push) moverrun = 1'b1;
    else if (clr) moverrun = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_done  = 1'b0;
    bus.rx_error = 1'b0;
    bus.rd_ready = 1'b0;
    clr_overrun  = 1'b0;
    check_status();
  endtask

  task automatic fill16();
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = mcount;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("sb_left", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.rx_error = 1'b0; bus.rd_ready = 1'b0;
    clr_overrun = 1'b0;
    #1;
    check_status();
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single byte, FWFT visible one cycle later, then pop
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1_data", {bus.rd_err, bus.rd_data}, 9'h0A5);
    drain();

    // 2: fill to full, drain in order
    fill16();
    drain();

    // 3: overflow drop, then clear
    fill16();
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // 4: full with simultaneous push and pop
    fill16();
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    drain();

    // 5: framing error flag travels with its byte
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("t5_err", {bus.rd_err, bus.rd_data}, 9'h13C);
    cycle(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    drain();

    // Empty with push and pop together: only the push takes effect
    cycle(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    drain();

    // Overrun set wins over a simultaneous clear
    fill16();
    cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h67, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // 6: interleaved traffic, then asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, (i % 2) == 1, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    mcount = 0;
    moverrun = 1'b0;
    check_status();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b1, 8'h9E, 1'b0, 1'b0, 1'b0);
    check("t6_data", {bus.rd_err, bus.rd_data}, 9'h09E);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
